// File: rtl/ras_ckpt.sv
// Return address stack with occupancy count, circular overflow and checkpoint repair.
// Outputs reflect registered state only; a push/pop/update shows up one cycle later.
module ras_ckpt #(
  parameter int ENTRIES      = 8,
  parameter int TARGET_WIDTH = 31,
  parameter int INDEX_WIDTH  = $clog2(ENTRIES),
  parameter int STAT_WIDTH   = 16
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    link_RESP,
  input  logic [TARGET_WIDTH-1:0] link_target_RESP,
  input  logic                    ret_RESP,
  output logic                    ret_valid_RESP,
  output logic [TARGET_WIDTH-1:0] ret_target_RESP,
  output logic [INDEX_WIDTH-1:0]  ras_index_RESP,
  output logic [INDEX_WIDTH:0]    ras_count_RESP,
  input  logic                    update_valid,
  input  logic [INDEX_WIDTH-1:0]  update_ras_index,
  input  logic [INDEX_WIDTH:0]    update_ras_count,
  input  logic                    update_restore_valid,
  input  logic [TARGET_WIDTH-1:0] update_restore_target,
  output logic [STAT_WIDTH-1:0]   overflow_events,
  output logic [STAT_WIDTH-1:0]   underflow_events
);

  localparam logic [INDEX_WIDTH:0] FULL = (INDEX_WIDTH+1)'(ENTRIES);

  logic [TARGET_WIDTH-1:0] stack [ENTRIES];
  logic [INDEX_WIDTH-1:0]  sp, sp_nxt, sp_inc, sp_dec;
  logic [INDEX_WIDTH:0]    count, count_nxt;
  logic                    wr_en;
  logic [INDEX_WIDTH-1:0]  wr_idx;
  logic [TARGET_WIDTH-1:0] wr_dat;
  logic                    ovf_inc, unf_inc;

  // ENTRIES is a power of two, so pointer wrap is plain INDEX_WIDTH-bit overflow.
  assign sp_inc = sp + 1'b1;
  assign sp_dec = sp - 1'b1;

  always_comb begin
    sp_nxt    = sp;
    count_nxt = count;
    wr_en     = 1'b0;
    wr_idx    = sp_inc;
    wr_dat    = link_target_RESP;
    ovf_inc   = 1'b0;
    unf_inc   = 1'b0;
    if (update_valid) begin
      sp_nxt    = update_ras_index;
      count_nxt = (update_ras_count > FULL) ? FULL : update_ras_count;
      wr_en     = update_restore_valid;
      wr_idx    = update_ras_index;
      wr_dat    = update_restore_target;
    end else if (link_RESP && ret_RESP) begin
      if (count != '0) begin
        wr_en  = 1'b1;
        wr_idx = sp;
      end else begin
        // Pop of an empty stack is a no-op, leaving a plain push.
        wr_en     = 1'b1;
        sp_nxt    = sp_inc;
        count_nxt = (INDEX_WIDTH+1)'(1);
        unf_inc   = 1'b1;
      end
    end else if (link_RESP) begin
      wr_en  = 1'b1;
      sp_nxt = sp_inc;
      if (count == FULL) ovf_inc = 1'b1;
      else               count_nxt = count + 1'b1;
    end else if (ret_RESP) begin
      if (count != '0) begin
        sp_nxt    = sp_dec;
        count_nxt = count - 1'b1;
      end else begin
        unf_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) stack[i] <= '0;
      sp               <= '0;
      count            <= '0;
      overflow_events  <= '0;
      underflow_events <= '0;
    end else begin
      if (wr_en) stack[wr_idx] <= wr_dat;
      sp    <= sp_nxt;
      count <= count_nxt;
      if (ovf_inc && (overflow_events != '1))  overflow_events  <= overflow_events + 1'b1;
      if (unf_inc && (underflow_events != '1)) underflow_events <= underflow_events + 1'b1;
    end
  end

  assign ret_target_RESP = stack[sp];
  assign ret_valid_RESP  = (count != '0);
  assign ras_index_RESP  = sp;
  assign ras_count_RESP  = count;

endmodule

// File: tb/tb_ras_ckpt.sv
// Directed bench for ras_ckpt (ENTRIES=8, narrow event counters so saturation is reachable).
module tb_ras_ckpt;
  localparam int ENTRIES = 8;
  localparam int TW      = 31;
  localparam int IW      = 3;
  localparam int SW      = 3;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          link_RESP, ret_RESP;
  logic [TW-1:0] link_target_RESP;
  logic          ret_valid_RESP;
  logic [TW-1:0] ret_target_RESP;
  logic [IW-1:0] ras_index_RESP;
  logic [IW:0]   ras_count_RESP;
  logic          update_valid, update_restore_valid;
  logic [IW-1:0] update_ras_index;
  logic [IW:0]   update_ras_count;
  logic [TW-1:0] update_restore_target;
  logic [SW-1:0] overflow_events, underflow_events;

  int errors = 0;
  int checks = 0;

  ras_ckpt #(.ENTRIES(ENTRIES), .TARGET_WIDTH(TW), .STAT_WIDTH(SW)) dut (
    .CLK(CLK), .nRST(nRST),
    .link_RESP(link_RESP), .link_target_RESP(link_target_RESP), .ret_RESP(ret_RESP),
    .ret_valid_RESP(ret_valid_RESP), .ret_target_RESP(ret_target_RESP),
    .ras_index_RESP(ras_index_RESP), .ras_count_RESP(ras_count_RESP),
    .update_valid(update_valid), .update_ras_index(update_ras_index),
    .update_ras_count(update_ras_count), .update_restore_valid(update_restore_valid),
    .update_restore_target(update_restore_target),
    .overflow_events(overflow_events), .underflow_events(underflow_events)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag, input int v, input int t, input int sp, input int cnt);
    check({tag, ".valid"}, 64'(ret_valid_RESP), 64'(v));
    check({tag, ".target"}, 64'(ret_target_RESP), 64'(t));
    check({tag, ".sp"}, 64'(ras_index_RESP), 64'(sp));
    check({tag, ".count"}, 64'(ras_count_RESP), 64'(cnt));
  endtask

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [TW-1:0] t);
    link_RESP = 1'b1; link_target_RESP = t;
    cycle();
    link_RESP = 1'b0;
  endtask

  task automatic pop();
    ret_RESP = 1'b1;
    cycle();
    ret_RESP = 1'b0;
  endtask

  task automatic update(input int idx, input int cnt, input logic rv, input logic [TW-1:0] t);
    update_valid = 1'b1; update_ras_index = IW'(idx); update_ras_count = (IW+1)'(cnt);
    update_restore_valid = rv; update_restore_target = t;
    cycle();
    update_valid = 1'b0; update_restore_valid = 1'b0;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    #2;
    nRST = 1'b1;
    cycle();
  endtask

  initial begin
    nRST = 1'b0; link_RESP = 0; ret_RESP = 0; link_target_RESP = '0;
    update_valid = 0; update_ras_index = '0; update_ras_count = '0;
    update_restore_valid = 0; update_restore_target = '0;
    #12;
    check_state("reset", 0, 0, 0, 0);
    check("reset.ovf", 64'(overflow_events), 64'd0);
    check("reset.unf", 64'(underflow_events), 64'd0);
    nRST = 1'b1;

    // Basic push/pop
    push(31'h100); push(31'h200); push(31'h300);
    check_state("push3", 1, 'h300, 3, 3);
    pop(); check_state("pop1", 1, 'h200, 2, 2);
    pop(); check_state("pop2", 1, 'h100, 1, 1);
    pop(); check_state("pop3", 0, 0, 0, 0);

    // Underflow and pop-then-push on empty
    pop();
    check_state("unf_pop", 0, 0, 0, 0);
    check("unf_pop.cnt", 64'(underflow_events), 64'd1);
    link_RESP = 1; ret_RESP = 1; link_target_RESP = 31'h44;
    cycle();
    link_RESP = 0; ret_RESP = 0;
    check_state("linkret_empty", 1, 'h44, 1, 1);
    check("linkret_empty.unf", 64'(underflow_events), 64'd2);
    // Pop-then-push on non-empty replaces top in place
    link_RESP = 1; ret_RESP = 1; link_target_RESP = 31'h55;
    cycle();
    link_RESP = 0; ret_RESP = 0;
    check_state("linkret_full", 1, 'h55, 1, 1);
    check("linkret_full.unf", 64'(underflow_events), 64'd2);

    // Circular overflow
    do_reset();
    for (int i = 1; i <= 10; i++) push(TW'(i));
    check_state("ovf10", 1, 10, 2, 8);
    check("ovf10.cnt", 64'(overflow_events), 64'd2);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d", i), 64'(ret_target_RESP), 64'(10 - i));
      pop();
    end
    check("drain.valid", 64'(ret_valid_RESP), 64'd0);
    check("drain.count", 64'(ras_count_RESP), 64'd0);

    // Checkpoint repair after wrong-path pop + push
    do_reset();
    push(31'hA); push(31'hB);
    check("ckpt.sp", 64'(ras_index_RESP), 64'd2);
    check("ckpt.count", 64'(ras_count_RESP), 64'd2);
    pop(); push(31'hC);
    check_state("wrongpath", 1, 'hC, 2, 2);
    update(2, 2, 1'b1, 31'hB);
    check_state("repair", 1, 'hB, 2, 2);
    pop();
    check_state("repair.pop", 1, 'hA, 1, 1);

    // Update wins over link; count clamp
    update_valid = 1; update_ras_index = 3'd5; update_ras_count = 4'd3;
    link_RESP = 1; link_target_RESP = 31'h77;
    cycle();
    update_valid = 0; link_RESP = 0;
    check_state("upd_link", 1, 0, 5, 3);
    check("upd_link.ovf", 64'(overflow_events), 64'd0);
    update(7, 15, 1'b0, '0);
    check_state("clamp", 1, 0, 7, 8);

    // Asynchronous reset mid-sequence
    do_reset();
    for (int i = 1; i <= 5; i++) push(TW'(i * 16));
    check_state("pre_rst", 1, 'h50, 5, 5);
    nRST = 1'b0;
    #1;
    check_state("async_rst", 0, 0, 0, 0);
    check("async_rst.ovf", 64'(overflow_events), 64'd0);
    #2;
    nRST = 1'b1;
    cycle();

    // Counter saturation (3-bit counters top out at 7)
    for (int i = 0; i < 15; i++) push(TW'(i));
    check("sat.ovf7", 64'(overflow_events), 64'd7);
    push(31'h99); push(31'h9A);
    check("sat.ovf_hold", 64'(overflow_events), 64'd7);
    check("sat.top", 64'(ret_target_RESP), 64'h9A);
    for (int i = 0; i < 8; i++) pop();
    for (int i = 0; i < 9; i++) pop();
    check("sat.unf_hold", 64'(underflow_events), 64'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not complete, errors=%0d", errors);
    $fatal(1);
  end
endmodule
